instr_fetch: RTL and testbench

Upstream stage of the single-cycle RV32I core: owns the program counter, fetches each instruction from instruction memory over a request/acknowledge handshake, and holds it in an instruction register. It presents the decoded fields (opcode, funct3, funct7 bit 5, register indices) to the controller and datapath. It advances the PC only when the datapath signals retirement. Because it holds state across cycles, the core tolerates multi-cycle instruction memory.

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake and holds the instruction register.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirects instead of truncating them.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemRdata,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  input  logic        i_pcSrc,
  input  logic [31:0] i_pcTarget,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [6:0]  o_operand,
  output logic [2:0]  o_funct3,
  output logic        o_funct7bit5,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_fetchError,
  output logic        o_misaligned
);

  localparam int unsigned WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_ERROR
  } state_e;

  state_e              state_q;
  logic [31:0]         pc_q;
  logic [31:0]         instr_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                req_q;
  logic                valid_q;
  logic                err_q;
  logic [31:0]         pc_d;

  // Redirect target is word-aligned by masking; sequential path wraps naturally.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (i_pcSrc) begin
      pc_d = i_pcTarget & 32'hFFFF_FFFC;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  logic redirect_bad;
  assign redirect_bad = i_pcSrc && (i_pcTarget[1:0] != 2'b00);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      wait_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (i_imemAck) begin
            instr_q <= i_imemRdata;
            wait_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_LAST) begin
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end
          end
        end
        S_ISSUE: begin
          if (i_instrReady) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_bad) begin
              err_q   <= 1'b1;
              mis_q   <= 1'b1;
              state_q <= S_ERROR;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
`else
            pc_q    <= pc_d;
            req_q   <= 1'b1;
            state_q <= S_REQ;
`endif
          end
        end
        S_ERROR: begin
          // Sticky until reset.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_imemReq    = req_q;
  assign o_imemAddr   = pc_q;
  assign o_pc         = pc_q;
  assign o_instrValid = valid_q;
  assign o_fetchError = err_q;
  assign o_instr      = instr_q;
  assign o_operand    = instr_q[6:0];
  assign o_funct3     = instr_q[14:12];
  assign o_funct7bit5 = instr_q[30];
  assign o_rs1        = instr_q[19:15];
  assign o_rs2        = instr_q[24:20];
  assign o_rd         = instr_q[11:7];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_misaligned = mis_q;
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expected values are hand-computed constants.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  operand;
  logic [2:0]  funct3;
  logic        funct7bit5;
  logic [4:0]  rs1, rs2, rd;
  logic        fetch_error;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imemReq(imem_req), .o_imemAddr(imem_addr),
    .i_imemAck(imem_ack), .i_imemRdata(imem_rdata),
    .o_instrValid(instr_valid), .i_instrReady(instr_ready),
    .i_pcSrc(pc_src), .i_pcTarget(pc_target),
    .o_pc(pc), .o_instr(instr), .o_operand(operand), .o_funct3(funct3),
    .o_funct7bit5(funct7bit5), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd),
    .o_fetchError(fetch_error), .o_misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h13);
    check("rst_operand", 32'(operand), 32'h13);
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_err", 32'(fetch_error), 0);
    check("rst_mis", 32'(misaligned), 0);

    // IDLE lasts one cycle, then the first request
    rst = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 1);

    // Back-to-back: 2 cycles per instruction
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("seq_addr", imem_addr, 32'(4 * k));
      check("seq_valid_lo", 32'(instr_valid), 0);
      tick();
      check("seq_valid_hi", 32'(instr_valid), 1);
      check("seq_req_lo", 32'(imem_req), 0);
      tick();
    end
    check("seq_addr_end", imem_addr, 32'd16);

    // Ack delayed three cycles
    imem_ack = 1'b0; instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("dly_valid_lo", 32'(instr_valid), 0);
    check("dly_req_hi", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = 32'h40B5_0533;
    tick();
    imem_ack = 1'b0;
    check("dly_valid_hi", 32'(instr_valid), 1);
    check("dly_instr", instr, 32'h40B5_0533);
    check("dly_operand", 32'(operand), 32'h33);
    check("dly_funct3", 32'(funct3), 0);
    check("dly_f7b5", 32'(funct7bit5), 1);
    check("dly_rd", 32'(rd), 10);
    check("dly_rs1", 32'(rs1), 10);
    check("dly_rs2", 32'(rs2), 11);

    // Hold in ISSUE while pc_src toggles
    pc_target = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      pc_src = ~pc_src;
      tick();
      check("hold_instr", instr, 32'h40B5_0533);
      check("hold_pc", pc, 32'd16);
      check("hold_valid", 32'(instr_valid), 1);
    end
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0100;
    tick();
    instr_ready = 1'b0; pc_src = 1'b0;
    check("redir_addr", imem_addr, 32'h100);
    check("redir_req", 32'(imem_req), 1);

    // Misaligned redirect
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0102;
    tick();
    instr_ready = 1'b0; pc_src = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_flag", 32'(misaligned), 1);
    check("mis_err", 32'(fetch_error), 1);
    check("mis_req", 32'(imem_req), 0);
    check("mis_pc", pc, 32'h100);
`else
    check("mis_addr", imem_addr, 32'h100);
    check("mis_flag", 32'(misaligned), 0);
    check("mis_req", 32'(imem_req), 1);
`endif

    // Timeout after MAX_WAIT unacknowledged REQ cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("to_req_start", 32'(imem_req), 1);
    for (int k = 0; k < 14; k++) tick();
    check("to_err_pre", 32'(fetch_error), 0);
    check("to_req_pre", 32'(imem_req), 1);
    tick();
    check("to_err", 32'(fetch_error), 1);
    check("to_req_off", 32'(imem_req), 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) tick();
    imem_ack = 1'b0;
    check("to_sticky", 32'(fetch_error), 1);
    check("to_req_stay", 32'(imem_req), 0);
    check("to_valid", 32'(instr_valid), 0);
    check("to_instr", instr, 32'h13);
    rst = 1'b1;
    tick();
    check("to_rst_pc", pc, 32'h0);
    check("to_rst_err", 32'(fetch_error), 0);

    // Reset during REQ, ack arrives in the IDLE cycle
    rst = 1'b0;
    tick();
    tick();
    check("mr_req", 32'(imem_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    check("mr_req_off", 32'(imem_req), 0);
    tick();
    imem_ack = 1'b0;
    check("mr_instr", instr, 32'h13);
    check("mr_valid", 32'(instr_valid), 0);
    check("mr_req_on", 32'(imem_req), 1);
    check("mr_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
